// File: rtl/fifo_pair_if.sv
// fifo_pair_if: producer/consumer handshake bundle for the two fifo_pair channels
interface fifo_pair_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    logic [DATA_W-1:0] data_in0;
    logic              data_in0_vld;
    logic              data_in0_rdy;
    logic [DATA_W-1:0] data_in1;
    logic              data_in1_vld;
    logic              data_in1_rdy;
    logic [DATA_W-1:0] data_out0;
    logic              data_out0_vld;
    logic              data_out0_rdy;
    logic [DATA_W-1:0] data_out1;
    logic              data_out1_vld;
    logic              data_out1_rdy;
    logic [LVL_W-1:0]  lvl0;
    logic [LVL_W-1:0]  lvl1;
    modport master (
        output data_in0, data_in0_vld, data_in1, data_in1_vld, data_out0_rdy, data_out1_rdy,
        input  data_in0_rdy, data_in1_rdy, data_out0, data_out0_vld, data_out1, data_out1_vld, lvl0, lvl1
    );
    modport slave (
        input  data_in0, data_in0_vld, data_in1, data_in1_vld, data_out0_rdy, data_out1_rdy,
        output data_in0_rdy, data_in1_rdy, data_out0, data_out0_vld, data_out1, data_out1_vld, lvl0, lvl1
    );
endinterface

// File: rtl/fifo_pair.sv
// fifo_pair: two independent valid/ready FIFO channels (in0 -> out0, in1 -> out1)
module fifo_pair #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    fifo_pair_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    logic [DATA_W-1:0] din  [2];
    logic [DATA_W-1:0] dout [2];
    logic              ivld [2];
    logic              irdy [2];
    logic              ovld [2];
    logic              ordy [2];
    logic [LVL_W-1:0]  lvl  [2];
    assign din[0]            = bus.data_in0;
    assign din[1]            = bus.data_in1;
    assign ivld[0]           = bus.data_in0_vld;
    assign ivld[1]           = bus.data_in1_vld;
    assign ordy[0]           = bus.data_out0_rdy;
    assign ordy[1]           = bus.data_out1_rdy;
    assign bus.data_in0_rdy  = irdy[0];
    assign bus.data_in1_rdy  = irdy[1];
    assign bus.data_out0     = dout[0];
    assign bus.data_out1     = dout[1];
    assign bus.data_out0_vld = ovld[0];
    assign bus.data_out1_vld = ovld[1];
    assign bus.lvl0          = lvl[0];
    assign bus.lvl1          = lvl[1];
    for (genvar g = 0; g < 2; g++) begin : ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [LVL_W-1:0]  count;
        logic [LVL_W-1:0]  count_nxt;
        logic              rdy_q;
        logic              vld_q;
        logic              push;
        logic              pop;
        assign push      = ivld[g] & rdy_q;
        assign pop       = vld_q & ordy[g];
        assign count_nxt = count + LVL_W'(push) - LVL_W'(pop);
        // payload storage; left unreset since vld gates every read
        always_ff @(posedge clk) begin
            if (push)
                mem[wr_ptr] <= din[g];
        end
        // pointers, occupancy and handshake flags, flags taken from next-state occupancy to avoid bubbles
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                vld_q  <= 1'b0;
                rdy_q  <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(push);
                rd_ptr <= rd_ptr + PTR_W'(pop);
                count  <= count_nxt;
                vld_q  <= count_nxt != '0;
                rdy_q  <= count_nxt != LVL_W'(DEPTH);
            end
        end
        assign dout[g] = mem[rd_ptr];
        assign irdy[g] = rdy_q;
        assign ovld[g] = vld_q;
        assign lvl[g]  = count;
    end
endmodule

// File: tb/tb_fifo_pair.sv
// tb_fifo_pair: randomized scoreboard bench for fifo_pair with a queue-based reference model
module tb_fifo_pair;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic alive = 1'b0;
    logic done  = 1'b0;
    int vectors = 0;
    int errors  = 0;
    int npop0   = 0;
    int npop1   = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    fifo_pair_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
    fifo_pair #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // producers may accept only from the first clock edge after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive <= 1'b0;
        else        alive <= 1'b1;
    end
    // monitor: compare observed state to the queues, then record this cycle's handshakes
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            chk("lvl0", 64'(bus.lvl0), 64'(q0.size()));
            chk("lvl1", 64'(bus.lvl1), 64'(q1.size()));
            chk("out_vld0", 64'(bus.data_out0_vld), 64'(q0.size() != 0));
            chk("out_vld1", 64'(bus.data_out1_vld), 64'(q1.size() != 0));
            chk("in_rdy0", 64'(bus.data_in0_rdy), 64'(alive && q0.size() != DEPTH));
            chk("in_rdy1", 64'(bus.data_in1_rdy), 64'(alive && q1.size() != DEPTH));
            if (bus.data_out0_vld && bus.data_out0_rdy) begin
                if (q0.size() == 0) chk("pop0_unexpected", 64'(bus.data_out0), 64'hdead);
                else begin
                    chk("data_out0", 64'(bus.data_out0), 64'(q0.pop_front()));
                    npop0++;
                end
            end
            if (bus.data_out1_vld && bus.data_out1_rdy) begin
                if (q1.size() == 0) chk("pop1_unexpected", 64'(bus.data_out1), 64'hdead);
                else begin
                    chk("data_out1", 64'(bus.data_out1), 64'(q1.pop_front()));
                    npop1++;
                end
            end
            if (bus.data_in0_vld && bus.data_in0_rdy) q0.push_back(bus.data_in0);
            if (bus.data_in1_vld && bus.data_in1_rdy) q1.push_back(bus.data_in1);
        end
    end
    task automatic put(input int ch, input logic [31:0] d);
        int n = 0;
        logic r;
        if (ch == 0) begin
            bus.data_in0     = d;
            bus.data_in0_vld = 1'b1;
        end else begin
            bus.data_in1     = d;
            bus.data_in1_vld = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
            r = (ch == 0) ? bus.data_in0_rdy : bus.data_in1_rdy;
        end while (!r && n < 2000);
        chk(ch == 0 ? "put0_accept" : "put1_accept", 64'(r), 64'd1);
        @(posedge clk);
        #1;
    endtask
    task automatic wait_empty(input int ch);
        int n = 0;
        while (((ch == 0) ? q0.size() : q1.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(ch == 0 ? "drain0" : "drain1", 64'((ch == 0) ? q0.size() : q1.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end
    initial begin
        int p;
        bus.data_in0      = '0;
        bus.data_in1      = '0;
        bus.data_in0_vld  = 1'b0;
        bus.data_in1_vld  = 1'b0;
        bus.data_out0_rdy = 1'b0;
        bus.data_out1_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_rdy0_low", 64'(bus.data_in0_rdy), 64'd0);
        chk("rst_rdy1_low", 64'(bus.data_in1_rdy), 64'd0);
        chk("rst_vld0", 64'(bus.data_out0_vld), 64'd0);
        chk("rst_lvl0", 64'(bus.lvl0), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_rdy0_high", 64'(bus.data_in0_rdy), 64'd1);
        chk("rel_rdy1_high", 64'(bus.data_in1_rdy), 64'd1);
        chk("rel_vld1", 64'(bus.data_out1_vld), 64'd0);
        chk("rel_lvl1", 64'(bus.lvl1), 64'd0);
        for (int i = 0; i < 4; i++) put(0, 32'hA0 + 32'(i));
        bus.data_in0 = 32'hA4;
        chk("full_lvl0", 64'(bus.lvl0), 64'd4);
        chk("full_rdy0", 64'(bus.data_in0_rdy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_hold_lvl0", 64'(bus.lvl0), 64'd4);
        bus.data_out0_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.data_out0_rdy = 1'b0;
        bus.data_in0_vld  = 1'b0;
        chk("fullpop_lvl0", 64'(bus.lvl0), 64'd3);
        chk("fullpop_rdy0", 64'(bus.data_in0_rdy), 64'd1);
        chk("fullpop_head", 64'(bus.data_out0), 64'hA1);
        bus.data_out0_rdy = 1'b1;
        wait_empty(0);
        chk("drained_lvl0", 64'(bus.lvl0), 64'd0);
        chk("drained_pops0", 64'(npop0), 64'd4);
        bus.data_out0_rdy = 1'b0;
        bus.data_out1_rdy = 1'b1;
        p = npop1;
        for (int i = 0; i < 100; i++) begin
            put(1, 32'(i));
            chk("stream_lvl1", 64'(bus.lvl1), 64'd1);
        end
        bus.data_in1_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("stream_pops1", 64'(npop1 - p), 64'd100);
        chk("stream_lvl1_end", 64'(bus.lvl1), 64'd0);
        fork
            begin
                fork
                    for (int k = 0; k < 1000; k++) begin
                        repeat ($urandom_range(0, 2)) begin
                            bus.data_in0_vld = 1'b0;
                            @(posedge clk);
                            #1;
                        end
                        put(0, 32'h0000_0000 + 32'(k));
                    end
                    for (int k = 0; k < 1000; k++) begin
                        repeat ($urandom_range(0, 2)) begin
                            bus.data_in1_vld = 1'b0;
                            @(posedge clk);
                            #1;
                        end
                        put(1, 32'h0000_1000 + 32'(k));
                    end
                join
                bus.data_in0_vld = 1'b0;
                bus.data_in1_vld = 1'b0;
                done = 1'b1;
            end
            while (!done) begin
                bus.data_out0_rdy = 1'($urandom);
                bus.data_out1_rdy = 1'($urandom);
                @(posedge clk);
                #1;
            end
        join
        bus.data_out0_rdy = 1'b1;
        bus.data_out1_rdy = 1'b1;
        wait_empty(0);
        wait_empty(1);
        bus.data_out0_rdy = 1'b0;
        for (int i = 0; i < 3; i++) put(0, 32'hB0 + 32'(i));
        chk("pre_rst_lvl0", 64'(bus.lvl0), 64'd3);
        bus.data_in0 = 32'hEE;
        rst_n = 1'b0;
        #1;
        chk("async_vld0", 64'(bus.data_out0_vld), 64'd0);
        chk("async_lvl0", 64'(bus.lvl0), 64'd0);
        chk("async_rdy0", 64'(bus.data_in0_rdy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        bus.data_in0_vld = 1'b0;
        rst_n = 1'b1;
        put(0, 32'h55);
        bus.data_in0_vld = 1'b0;
        chk("post_rst_head", 64'(bus.data_out0), 64'h55);
        chk("post_rst_vld0", 64'(bus.data_out0_vld), 64'd1);
        bus.data_out0_rdy = 1'b1;
        wait_empty(0);
        chk("final_lvl0", 64'(bus.lvl0), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
